// File: rtl/fifo_stream_reader.sv
// Read-side master for syncfifo: issues FIFO reads, absorbs the one-cycle
// registered read latency and presents a valid/ready stream with a burst "last" tag.
module fifo_stream_reader #(
    parameter int unsigned datawidth = 32,
    parameter int unsigned lenwidth  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [lenwidth-1:0]  burst_len,
    output logic                 fifo_cs,
    output logic                 fifo_ren,
    input  logic [datawidth-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [datawidth-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic [15:0]          words_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [lenwidth-1:0] ONE = lenwidth'(1);

    logic [1:0]           state;
    logic [1:0]           occ;
    logic                 pend;
    logic [lenwidth-1:0]  cnt;
    logic [lenwidth-1:0]  cnt_inc;
    logic [lenwidth-1:0]  burst_len_q;
    logic [datawidth-1:0] data0;
    logic [datawidth-1:0] data1;
    logic                 last0;
    logic                 last1;
    logic                 pop;
    logic                 push;
    logic                 push_last;
    logic                 start;
    logic [2:0]           inflight;
    logic [1:0]           slot;

    assign m_valid   = (occ != 2'd0);
    assign m_data    = data0;
    assign m_last    = last0 & m_valid;
    assign pop       = m_valid & m_ready;
    assign push      = pend;
    assign busy      = (state != IDLE);
    assign start     = (state == IDLE) & en;
    assign cnt_inc   = cnt + ONE;
    assign push_last = (burst_len_q != '0) && (cnt_inc == burst_len_q);

    // Words already committed to the buffer after this edge; a read is only
    // issued when its returning word is guaranteed a free slot.
    assign inflight = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign fifo_ren = (state == RUN) & en & ~fifo_empty & (inflight < 3'd2);
    assign fifo_cs  = fifo_ren;

    // Tail index for the incoming word, taking a same-cycle pop into account.
    assign slot = occ - {1'b0, pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            burst_len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state       <= RUN;
                        burst_len_q <= burst_len;
                    end
                end
                RUN: begin
                    if (!en) state <= DRAIN;
                end
                DRAIN: begin
                    if (en) state <= RUN;
                    else if (!pend && occ == 2'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else begin
            pend <= fifo_ren;
            if (start) cnt <= '0;
            else if (push) cnt <= push_last ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ   <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            assert (!(push && slot == 2'd2));
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                data0 <= data1;
                last0 <= last1;
            end
            if (push) begin
                if (slot == 2'd0) begin
                    data0 <= fifo_dout;
                    last0 <= push_last;
                end else begin
                    data1 <= fifo_dout;
                    last1 <= push_last;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_out <= '0;
        end else if (pop && words_out != 16'hFFFF) begin
            words_out <= words_out + 16'd1;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural FIFO feeds the reader and every
// delivered word is compared against the FIFO write order and burst position.
module tb_fifo_stream_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [LW-1:0] burst_len;
    logic          fifo_cs;
    logic          fifo_ren;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic [15:0]   words_out;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Behavioural source FIFO: written by the stimulus, read by the DUT.
    logic [DW-1:0] mem [0:1023];
    int unsigned   wp = 0;
    int unsigned   rp = 0;
    // Stream model: next word expected, burst length and beat since start.
    int unsigned   exp_rp = 0;
    int unsigned   bl_model = 0;
    int unsigned   beat = 0;
    int unsigned   pops = 0;

    fifo_stream_reader #(.datawidth(DW), .lenwidth(LW)) dut (
        .clk(clk), .rst(rst), .en(en), .burst_len(burst_len),
        .fifo_cs(fifo_cs), .fifo_ren(fifo_ren), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .words_out(words_out)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_ren) begin
            fifo_dout <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    function automatic logic [DW-1:0] exp_word();
        return mem[exp_rp % 1024];
    endfunction

    function automatic logic exp_last();
        return (bl_model != 0) && (((beat + 1) % bl_model) == 0);
    endfunction

    task automatic preload(input int unsigned n, input logic [DW-1:0] base);
        for (int unsigned i = 0; i < n; i++) begin
            mem[wp % 1024] = base + DW'(i);
            wp++;
        end
    endtask

    task automatic start_run(input logic [LW-1:0] bl);
        burst_len = bl;
        bl_model  = int'(bl);
        beat      = 0;
        en        = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; m_ready = 1'b0; burst_len = '0;
        repeat (3) @(negedge clk);
        #1;
        nvec++;
        if ({m_valid, m_last, busy, fifo_ren, fifo_cs} !== 5'b0 || m_data !== '0 || words_out !== 16'd0) begin
            nerr++;
            $display("FAIL reset_outputs got v=%b l=%b busy=%b ren=%b cs=%b data=%h wo=%0d want all zero",
                     m_valid, m_last, busy, fifo_ren, fifo_cs, m_data, words_out);
        end
        @(negedge clk);
        rst = 1'b1;
        pops = 0;
    endtask

    task automatic test_stream;
        int first_ren = -1, first_valid = -1, first_pop = -1, last_pop = -1;
        preload(8, 32'h100);
        m_ready = 1'b1;
        start_run(8'd4);
        for (int c = 0; c < 40 && exp_rp != wp; c++) begin
            @(negedge clk);
            #1;
            if (fifo_ren && first_ren < 0) first_ren = c;
            if (m_valid && first_valid < 0) first_valid = c;
            if (m_valid && m_ready) begin
                nvec++;
                if (m_data !== exp_word() || m_last !== exp_last()) begin
                    nerr++;
                    $display("FAIL stream_pop%0d got %h/%b want %h/%b", beat, m_data, m_last, exp_word(), exp_last());
                end
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                exp_rp++; beat++; pops++;
            end
        end
        nvec++;
        if (first_ren < 0 || first_valid - first_ren != 2) begin
            nerr++;
            $display("FAIL stream_latency got %0d cycles want 2", first_valid - first_ren);
        end
        nvec++;
        if (exp_rp != wp || last_pop - first_pop != 7) begin
            nerr++;
            $display("FAIL stream_b2b got %0d words over %0d cycles want 8 over 8", pops, last_pop - first_pop + 1);
        end
        @(negedge clk);
        #1;
        nvec++;
        if (words_out !== 16'(pops) || rp != wp || m_valid !== 1'b0) begin
            nerr++;
            $display("FAIL stream_end got wo=%0d reads=%0d v=%b want wo=%0d reads=%0d v=0", words_out, rp, m_valid, pops, wp);
        end
        en = 1'b0;
        for (int c = 0; c < 20 && busy !== 1'b0; c++) begin @(negedge clk); #1; end
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL stream_idle busy=%b want 0", busy); end
    endtask

    task automatic test_backpressure;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        int unsigned   outstanding;
        preload(8, 32'h100);
        start_run(8'd4);
        for (int c = 0; c < 300 && exp_rp != wp; c++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 2) == 0);
            #1;
            if (prev_stall) begin
                nvec++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    nerr++;
                    $display("FAIL bp_hold got v=%b %h/%b want v=1 %h/%b", m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            outstanding = rp + int'(fifo_ren) - exp_rp - int'(m_valid && m_ready);
            nvec++;
            if (outstanding > 2) begin
                nerr++;
                $display("FAIL bp_capacity got %0d words in flight want <=2", outstanding);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                nvec++;
                if (m_data !== exp_word() || m_last !== exp_last()) begin
                    nerr++;
                    $display("FAIL bp_pop%0d got %h/%b want %h/%b", beat, m_data, m_last, exp_word(), exp_last());
                end
                exp_rp++; beat++; pops++;
            end
        end
        nvec++;
        if (exp_rp != wp) begin nerr++; $display("FAIL bp_done got %0d words want %0d", exp_rp, wp); end
        en = 1'b0;
        for (int c = 0; c < 20 && busy !== 1'b0; c++) begin @(negedge clk); #1; end
        nvec++;
        if (busy !== 1'b0 || words_out !== 16'(pops)) begin
            nerr++;
            $display("FAIL bp_end got busy=%b wo=%0d want busy=0 wo=%0d", busy, words_out, pops);
        end
    endtask

    task automatic test_empty_resume;
        m_ready = 1'b1;
        preload(3, 32'h180);
        start_run(8'd0);
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 40 && exp_rp != wp; c++) begin
                @(negedge clk);
                #1;
                if (m_valid && m_ready) begin
                    nvec++;
                    if (m_data !== exp_word() || m_last !== exp_last()) begin
                        nerr++;
                        $display("FAIL er_pop%0d got %h/%b want %h/%b", beat, m_data, m_last, exp_word(), exp_last());
                    end
                    exp_rp++; beat++; pops++;
                end
            end
            nvec++;
            if (exp_rp != wp) begin nerr++; $display("FAIL er_done%0d got %0d words want %0d", phase, exp_rp, wp); end
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                #1;
                nvec++;
                if (fifo_ren !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1) begin
                    nerr++;
                    $display("FAIL er_starved got ren=%b v=%b busy=%b want 0 0 1", fifo_ren, m_valid, busy);
                end
            end
            if (phase == 0) preload(1, 32'h200);
        end
        en = 1'b0;
        for (int c = 0; c < 20 && busy !== 1'b0; c++) begin @(negedge clk); #1; end
        nvec++;
        if (busy !== 1'b0 || words_out !== 16'(pops)) begin
            nerr++;
            $display("FAIL er_end got busy=%b wo=%0d want busy=0 wo=%0d", busy, words_out, pops);
        end
    endtask

    task automatic test_drain;
        preload(4, 32'h300);
        m_ready = 1'b0;
        @(negedge clk);
        start_run(8'd0);
        @(negedge clk);
        #1;
        nvec++;
        if (fifo_ren !== 1'b1) begin nerr++; $display("FAIL drain_first_ren got %b want 1", fifo_ren); end
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            nvec++;
            if (fifo_ren !== 1'b0 || busy !== 1'b1) begin
                nerr++;
                $display("FAIL drain_hold got ren=%b busy=%b want 0 1", fifo_ren, busy);
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 20 && busy !== 1'b0; c++) begin
            #1;
            if (m_valid && m_ready) begin
                nvec++;
                if (m_data !== exp_word() || m_last !== exp_last()) begin
                    nerr++;
                    $display("FAIL drain_pop%0d got %h/%b want %h/%b", beat, m_data, m_last, exp_word(), exp_last());
                end
                exp_rp++; beat++; pops++;
            end
            @(negedge clk);
        end
        #1;
        nvec++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || exp_rp != rp || fifo_ren !== 1'b0) begin
            nerr++;
            $display("FAIL drain_end got busy=%b v=%b delivered=%0d ren=%b want 0 0 %0d 0", busy, m_valid, exp_rp, fifo_ren, rp);
        end
    endtask

    task automatic test_burst_len;
        int unsigned nlast;
        preload(10, 32'h400);
        for (int phase = 0; phase < 2; phase++) begin
            nlast = 0;
            start_run(phase == 0 ? 8'd0 : 8'd3);
            for (int c = 0; c < 300 && exp_rp != wp; c++) begin
                @(negedge clk);
                m_ready = ($urandom_range(0, 3) != 0);
                if (phase == 0 && beat == 5) burst_len = 8'd3;
                #1;
                if (m_valid && m_ready) begin
                    nvec++;
                    if (m_data !== exp_word() || m_last !== exp_last()) begin
                        nerr++;
                        $display("FAIL bl%0d_pop%0d got %h/%b want %h/%b", phase, beat, m_data, m_last, exp_word(), exp_last());
                    end
                    if (m_last) nlast++;
                    exp_rp++; beat++; pops++;
                end
            end
            nvec++;
            if (exp_rp != wp || nlast != (phase == 0 ? 0 : 3)) begin
                nerr++;
                $display("FAIL bl%0d_done got %0d words %0d lasts want %0d words %0d lasts",
                         phase, exp_rp, nlast, wp, (phase == 0 ? 0 : 3));
            end
            en = 1'b0;
            for (int c = 0; c < 20 && busy !== 1'b0; c++) begin @(negedge clk); #1; end
            nvec++;
            if (busy !== 1'b0) begin nerr++; $display("FAIL bl%0d_idle busy=%b want 0", phase, busy); end
            if (phase == 0) preload(9, 32'h500);
        end
    endtask

    task automatic test_reset_midflight;
        preload(6, 32'h600);
        m_ready = 1'b0;
        @(negedge clk);
        start_run(8'd2);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        nvec++;
        if ({m_valid, m_last, busy, fifo_ren, fifo_cs} !== 5'b0 || m_data !== '0 || words_out !== 16'd0) begin
            nerr++;
            $display("FAIL rst_async got v=%b l=%b busy=%b ren=%b cs=%b data=%h wo=%0d want all zero",
                     m_valid, m_last, busy, fifo_ren, fifo_cs, m_data, words_out);
        end
        nvec++;
        if (rp - exp_rp != 2) begin nerr++; $display("FAIL rst_reads got %0d reads in flight want 2", rp - exp_rp); end
        en = 1'b0;
        exp_rp = rp;
        pops = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        start_run(8'd2);
        for (int c = 0; c < 40 && exp_rp != wp; c++) begin
            @(negedge clk);
            #1;
            if (m_valid && m_ready) begin
                nvec++;
                if (m_data !== exp_word() || m_last !== exp_last()) begin
                    nerr++;
                    $display("FAIL rst_pop%0d got %h/%b want %h/%b", beat, m_data, m_last, exp_word(), exp_last());
                end
                exp_rp++; beat++; pops++;
            end
        end
        en = 1'b0;
        for (int c = 0; c < 20 && busy !== 1'b0; c++) begin @(negedge clk); #1; end
        nvec++;
        if (exp_rp != wp || busy !== 1'b0 || words_out !== 16'd4) begin
            nerr++;
            $display("FAIL rst_resume got words=%0d busy=%b wo=%0d want words=%0d busy=0 wo=4", exp_rp, busy, words_out, wp);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_empty_resume;
        test_drain;
        test_burst_len;
        test_reset_midflight;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
